// File: rtl/rtc_pkg.sv
// Shared definitions for the rtc command sequencer and the rtc block it loads.
package rtc_pkg;

    localparam int PERIOD_W  = 40;
    localparam int NS_W      = 38;
    localparam int SEC_W     = 48;
    localparam int ADJ_CNT_W = 32;

    // Nanoseconds per second, scaled by 256 for the 8-bit fractional field.
    localparam logic [NS_W-1:0] TIME_ACC_MODULO_DEF = 38'd256000000000;

    typedef enum logic [1:0] {
        OP_PERIOD = 2'b00,
        OP_TIME   = 2'b01,
        OP_ADJ    = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_ZERO    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_ADJ_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/rtc_ctrl.sv
// Command sequencer driving the rtc load interface.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so exactly one
// command is in flight. Completion is a single-cycle rsp_valid with rsp_err.
// The command is checked as it is accepted; the verdict is held in err_q and
// ISSUE either fires the matching load strobe or skips straight to RESP.
// Data outputs are registered at acceptance, only for commands that will
// strobe, so they are stable during the strobe and hold between commands.
module rtc_ctrl
    import rtc_pkg::*;
#(
    parameter logic [NS_W-1:0] TIME_ACC_MODULO = TIME_ACC_MODULO_DEF,
    parameter int unsigned     ADJ_TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [PERIOD_W-1:0]  cmd_period,
    input  logic [NS_W-1:0]      cmd_ns,
    input  logic [SEC_W-1:0]     cmd_sec,
    input  logic [ADJ_CNT_W-1:0] cmd_adj_cnt,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic                 period_ld,
    output logic                 time_ld,
    output logic                 adj_ld,
    output logic [PERIOD_W-1:0]  period_in,
    output logic [NS_W-1:0]      time_reg_ns_in,
    output logic [SEC_W-1:0]     time_reg_sec_in,
    output logic [PERIOD_W-1:0]  period_adj,
    output logic [ADJ_CNT_W-1:0] adj_ld_data,
    input  logic                 adj_ld_done,
    output state_e               dbg_state
);

    localparam logic [NS_W-1:0] NS_LIMIT = TIME_ACC_MODULO >> 8;
    localparam logic [15:0]     TO_LAST  = 16'(ADJ_TIMEOUT);

    state_e      state_q, state_d;
    op_e         op_q;
    err_e        err_q, err_d;
    err_e        acc_err;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic        accept;

    assign accept  = (state_q == ST_IDLE) && cmd_valid;
    assign cnt_inc = cnt_q + 16'd1;

    // Verdict on the command currently presented by the host.
    always_comb begin
        acc_err = ERR_OK;
        case (op_e'(cmd_op))
            OP_TIME:  if ({8'd0, cmd_ns[NS_W-1:8]} >= NS_LIMIT) acc_err = ERR_RANGE;
            OP_ADJ:   if (cmd_adj_cnt == '0) acc_err = ERR_ZERO;
            OP_RSVD:  acc_err = ERR_RANGE;
            default:  acc_err = ERR_OK;
        endcase
    end

    // State, latched op/verdict and the shared settle/timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PERIOD;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (accept) op_q <= op_e'(cmd_op);
        end
    end

    // Next-state logic; SETTLE reuses the counter to mask a stale done.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_ISSUE;
                    err_d   = acc_err;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (err_q == ERR_OK && op_q == OP_ADJ) state_d = ST_SETTLE;
                else                                   state_d = ST_RESP;
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_ADJ_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ADJ_WAIT: begin
                if (adj_ld_done) begin
                    state_d = ST_RESP;
                    err_d   = ERR_OK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LAST) begin
                        state_d = ST_RESP;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Data outputs load only for commands that will produce a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_in       <= '0;
            time_reg_ns_in  <= '0;
            time_reg_sec_in <= '0;
            period_adj      <= '0;
            adj_ld_data     <= '0;
        end else if (accept && acc_err == ERR_OK) begin
            case (op_e'(cmd_op))
                OP_PERIOD: period_in <= cmd_period;
                OP_TIME: begin
                    time_reg_ns_in  <= cmd_ns;
                    time_reg_sec_in <= cmd_sec;
                end
                OP_ADJ: begin
                    period_adj  <= cmd_period;
                    adj_ld_data <= cmd_adj_cnt;
                end
                default: ;
            endcase
        end
    end

    // Status and strobes decode straight from registered state so reset clears them at once.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) ? err_q : ERR_OK;
        period_ld = (state_q == ST_ISSUE) && (err_q == ERR_OK) && (op_q == OP_PERIOD);
        time_ld   = (state_q == ST_ISSUE) && (err_q == ERR_OK) && (op_q == OP_TIME);
        adj_ld    = (state_q == ST_ISSUE) && (err_q == ERR_OK) && (op_q == OP_ADJ);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_rtc_ctrl.sv
// Directed bench for rtc_ctrl: vector table for single-shot commands plus
// hand sequences for adjustment, timeout, stale done and mid-run reset.
module tb_rtc_ctrl;
  import rtc_pkg::*;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [39:0]  cmd_period;
  logic [37:0]  cmd_ns;
  logic [47:0]  cmd_sec;
  logic [31:0]  cmd_adj_cnt;
  logic         rsp_valid;
  logic [1:0]   rsp_err;
  logic         busy;
  logic         period_ld, time_ld, adj_ld;
  logic [39:0]  period_in;
  logic [37:0]  time_reg_ns_in;
  logic [47:0]  time_reg_sec_in;
  logic [39:0]  period_adj;
  logic [31:0]  adj_ld_data;
  logic         adj_ld_done;
  state_e       dbg_state;

  int checks = 0;
  int errors = 0;

  // expected values of the held data outputs
  logic [39:0] exp_period;
  logic [37:0] exp_ns;
  logic [47:0] exp_sec;
  logic [39:0] exp_padj;
  logic [31:0] exp_adj_data;

  typedef struct {
    logic [1:0]  op;
    logic [39:0] period;
    logic [37:0] ns;
    logic [47:0] sec;
    logic [31:0] cnt;
    logic [2:0]  exp_stb;   // {period_ld, time_ld, adj_ld}
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[7];

  rtc_ctrl #(
    .TIME_ACC_MODULO(38'd256000000),
    .ADJ_TIMEOUT(50)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_period(cmd_period),
    .cmd_ns(cmd_ns),
    .cmd_sec(cmd_sec),
    .cmd_adj_cnt(cmd_adj_cnt),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .busy(busy),
    .period_ld(period_ld),
    .time_ld(time_ld),
    .adj_ld(adj_ld),
    .period_in(period_in),
    .time_reg_ns_in(time_reg_ns_in),
    .time_reg_sec_in(time_reg_sec_in),
    .period_adj(period_adj),
    .adj_ld_data(adj_ld_data),
    .adj_ld_done(adj_ld_done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string tag);
    chk({tag, "_period_in"}, 64'(period_in), 64'(exp_period));
    chk({tag, "_ns_in"}, 64'(time_reg_ns_in), 64'(exp_ns));
    chk({tag, "_sec_in"}, 64'(time_reg_sec_in), 64'(exp_sec));
    chk({tag, "_period_adj"}, 64'(period_adj), 64'(exp_padj));
    chk({tag, "_adj_data"}, 64'(adj_ld_data), 64'(exp_adj_data));
  endtask

  // Present one command for a single cycle; returns at the ISSUE-cycle negedge.
  task automatic send(input logic [1:0] op, input logic [39:0] per, input logic [37:0] ns,
                      input logic [47:0] sec, input logic [31:0] cnt);
    @(negedge clk);
    cmd_op      = op;
    cmd_period  = per;
    cmd_ns      = ns;
    cmd_sec     = sec;
    cmd_adj_cnt = cnt;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  // Adjustment run: done raised at negedge done_k after ISSUE (never if < 0).
  task automatic adj_seq(input string tag, input logic [31:0] cnt, input logic [39:0] padj,
                         input int done_k, input bit stale, input int exp_k,
                         input logic [1:0] exp_err, input bit poke);
    int  rsp_k;
    bit  early_ld;
    bit  poke_ld;
    bit  poke_rdy;
    rsp_k    = -1;
    early_ld = 1'b0;
    poke_ld  = 1'b0;
    poke_rdy = 1'b0;
    adj_ld_done = stale;
    send(OP_ADJ, padj, 38'd0, 48'd0, cnt);
    exp_padj     = padj;
    exp_adj_data = cnt;
    chk({tag, "_adj_ld"}, 64'(adj_ld), 64'd1);
    chk({tag, "_stb_others"}, 64'({period_ld, time_ld}), 64'd0);
    chk_data(tag);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_k = k;
        break;
      end
      if (adj_ld) early_ld = 1'b1;
      if (poke && period_ld) poke_ld = 1'b1;
      if (poke && cmd_ready) poke_rdy = 1'b1;
      if (stale && k == 2) adj_ld_done = 1'b0;
      if (k == done_k) adj_ld_done = 1'b1;
      if (poke && k == 5) begin
        cmd_op     = OP_PERIOD;
        cmd_period = 40'h11_22334455;
        cmd_valid  = 1'b1;
      end
      if (poke && k == 40) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk({tag, "_rsp_cycle"}, 64'(rsp_k), 64'(exp_k));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
    chk({tag, "_single_adj_ld"}, 64'(early_ld), 64'd0);
    if (poke) begin
      chk({tag, "_busy_no_accept"}, 64'(poke_ld), 64'd0);
      chk({tag, "_busy_ready_low"}, 64'(poke_rdy), 64'd0);
    end
    adj_ld_done = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int  seen;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_period = '0;
    cmd_ns = '0;
    cmd_sec = '0;
    cmd_adj_cnt = '0;
    adj_ld_done = 1'b0;
    exp_period = '0;
    exp_ns = '0;
    exp_sec = '0;
    exp_padj = '0;
    exp_adj_data = '0;

    vecs[0] = '{OP_PERIOD, 40'h08_00000000, 38'd0, 48'd0, 32'd0, 3'b100, ERR_OK};
    vecs[1] = '{OP_TIME, 40'd0, {30'd999900, 8'h00}, 48'd10, 32'd0, 3'b010, ERR_OK};
    vecs[2] = '{OP_TIME, 40'd0, {30'd1000000, 8'h00}, 48'd77, 32'd0, 3'b000, ERR_RANGE};
    vecs[3] = '{OP_TIME, 40'd0, {30'd999999, 8'hFF}, 48'hFFFF_FFFF_FFFF, 32'd0, 3'b010, ERR_OK};
    vecs[4] = '{OP_RSVD, 40'h55_55555555, 38'd5, 48'd5, 32'd5, 3'b000, ERR_RANGE};
    vecs[5] = '{OP_ADJ, 40'hAA_AAAAAAAA, 38'd0, 48'd0, 32'd0, 3'b000, ERR_ZERO};
    vecs[6] = '{OP_PERIOD, 40'hFF_FFFFFFFF, 38'd0, 48'd0, 32'd0, 3'b100, ERR_OK};

    // reset state
    #1;
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("reset_strobes", 64'({period_ld, time_ld, adj_ld}), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk_data("reset");
    @(negedge clk);
    rst = 1'b1;

    // single-shot commands from the table
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].period, vecs[i].ns, vecs[i].sec, vecs[i].cnt);
      if (vecs[i].exp_stb[2]) exp_period = vecs[i].period;
      if (vecs[i].exp_stb[1]) begin
        exp_ns  = vecs[i].ns;
        exp_sec = vecs[i].sec;
      end
      chk($sformatf("v%0d_strobes", i), 64'({period_ld, time_ld, adj_ld}), 64'(vecs[i].exp_stb));
      chk($sformatf("v%0d_issue_busy", i), 64'({busy, cmd_ready, rsp_valid}), 64'(3'b100));
      chk_data($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_rsp_strobes", i), 64'({period_ld, time_ld, adj_ld}), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), 64'({rsp_valid, busy, cmd_ready}), 64'(3'b001));
    end

    // adjust: done 30 cycles after adj_ld
    adj_seq("adj_ok", 32'd100, 40'hFB_00000000, 30, 1'b0, 31, ERR_OK, 1'b0);
    // stale done held through SETTLE, real done later
    adj_seq("adj_stale", 32'd7, 40'hFC_00000000, 10, 1'b1, 11, ERR_OK, 1'b0);
    // timeout with a command poked while busy
    adj_seq("adj_timeout", 32'd5, 40'hFD_00000000, -1, 1'b0, 53, ERR_TIMEOUT, 1'b1);
    // done arrives on the terminal count: success wins
    adj_seq("adj_tie", 32'd9, 40'hFE_00000000, 52, 1'b0, 53, ERR_OK, 1'b0);

    // reset in the middle of a strobe
    send(OP_PERIOD, 40'h12_34567890, 38'd0, 48'd0, 32'd0);
    chk("mid_pre_strobe", 64'(period_ld), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    exp_period = '0;
    exp_ns = '0;
    exp_sec = '0;
    exp_padj = '0;
    exp_adj_data = '0;
    chk("mid_strobe_low", 64'({period_ld, time_ld, adj_ld}), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    chk_data("mid");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_no_rsp", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
